// File: rtl/t03_vga_output_stage.sv
// VGA raster timing generator and fixed-priority pixel compositor.
// Counters address the layer blocks; two pipeline stages re-align the
// layers' registered colours with their flags and with sync/de.
module t03_vga_output_stage #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter logic [7:0]  BG_COLOR  = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  layer_en,
  input  logic [31:0] layer_color,
  output logic [10:0] Hcnt,
  output logic [10:0] Vcnt,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [2:0]  red,
  output logic [2:0]  green,
  output logic [1:0]  blue,
  output logic        frame_tick
);

  localparam int unsigned CW      = 11;
  localparam int unsigned NL      = 4;
  localparam int unsigned PW      = 8;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS   = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS   = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_VISIBLE + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_VISIBLE + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_VISIBLE + V_FP + V_SYNC);

  logic          w_visible;
  logic          w_hs_act;
  logic          w_vs_act;
  logic [NL-1:0] r_en_d;
  logic          r_vis_d;
  logic          r_hs_d;
  logic          r_vs_d;
  logic [PW-1:0] w_pix;

  // Raster counters: Hcnt every clock, Vcnt on each line wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Hcnt <= '0;
      Vcnt <= '0;
    end else if (Hcnt == H_LAST) begin
      Hcnt <= '0;
      Vcnt <= (Vcnt == V_LAST) ? '0 : Vcnt + CW'(1);
    end else begin
      Hcnt <= Hcnt + CW'(1);
    end
  end

  // Visible region and sync windows decoded from the current counters
  always_comb begin
    w_visible = (Hcnt < H_VIS) && (Vcnt < V_VIS);
    w_hs_act  = (Hcnt >= HS_BEG) && (Hcnt < HS_END);
    w_vs_act  = (Vcnt >= VS_BEG) && (Vcnt < VS_END);
  end

  // Stage 1: delay flags one clock to meet the layers' registered colours
  // (syncs held active-high here so a cleared register means inactive)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en_d  <= '0;
      r_vis_d <= 1'b0;
      r_hs_d  <= 1'b0;
      r_vs_d  <= 1'b0;
    end else begin
      r_en_d  <= layer_en;
      r_vis_d <= w_visible;
      r_hs_d  <= w_hs_act;
      r_vs_d  <= w_vs_act;
    end
  end

  // Compositor: lowest-index owning layer wins, blanking forces black
  always_comb begin
    w_pix = BG_COLOR;
    for (int i = int'(NL) - 1; i >= 0; i--) begin
      if (r_en_d[i]) w_pix = layer_color[PW*i +: PW];
    end
    if (!r_vis_d) w_pix = '0;
  end

  // Stage 2: registered pixel, data enable and active-low syncs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      de    <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      {red, green, blue} <= w_pix;
      de    <= r_vis_d;
      hsync <= ~r_hs_d;
      vsync <= ~r_vs_d;
    end
  end

  // Start of vertical blanking, decoded from the registered counters
  assign frame_tick = (Hcnt == '0) && (Vcnt == V_VIS);

endmodule

// File: tb/tb_t03_vga_output_stage.sv
// Randomized bench: a small-geometry instance with random layer traffic and
// a default-geometry instance with every layer claiming every pixel, both
// compared each cycle against an arithmetic raster/priority model.
module tb_t03_vga_output_stage;

  // Small geometry keeps several full frames within the cycle budget
  localparam int SHV = 16, SHF = 4, SHS = 6, SHB = 6;
  localparam int SVV = 10, SVF = 2, SVS = 2, SVB = 3;
  localparam logic [7:0] SBG = 8'h25;
  // Default geometry
  localparam int BHV = 640, BHF = 16, BHS = 96, BHB = 48;
  localparam int BVV = 480, BVF = 10, BVS = 2, BVB = 33;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  s_en = 4'h0;
  logic [31:0] s_col = 32'h0;
  logic [10:0] s_h, s_v, b_h, b_v;
  logic        s_hs, s_vs, s_de, s_ft, b_hs, b_vs, b_de, b_ft;
  logic [2:0]  s_r, s_g, b_r, b_g;
  logic [1:0]  s_b, b_b;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0]  en_hist  [4];
  logic [31:0] col_hist [4];

  always #5 clk = ~clk;

  t03_vga_output_stage #(
    .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .BG_COLOR(SBG)
  ) u_small (
    .clk(clk), .rst(rst), .layer_en(s_en), .layer_color(s_col),
    .Hcnt(s_h), .Vcnt(s_v), .hsync(s_hs), .vsync(s_vs), .de(s_de),
    .red(s_r), .green(s_g), .blue(s_b), .frame_tick(s_ft)
  );

  t03_vga_output_stage u_big (
    .clk(clk), .rst(rst), .layer_en(4'hF), .layer_color(32'hFFFF_FFFF),
    .Hcnt(b_h), .Vcnt(b_v), .hsync(b_hs), .vsync(b_vs), .de(b_de),
    .red(b_r), .green(b_g), .blue(b_b), .frame_tick(b_ft)
  );

  // Count one comparison and report it if it disagrees
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Pixel a correct output stage must show for raster position (h,v)
  function automatic logic [7:0] model_pix(int h, int v, int hv, int vv,
                                           logic [3:0] en, logic [31:0] col, logic [7:0] bg);
    if (h >= hv || v >= vv) return 8'h00;
    for (int i = 0; i < 4; i++) if (en[i]) return col[8*i +: 8];
    return bg;
  endfunction

  // Compare one instance, n clocks after reset release, against the model
  task automatic check_inst(input string p, input int n,
                            input int hv, input int hf, input int hs, input int hb,
                            input int vv, input int vf, input int vs, input int vb,
                            input logic [3:0] en, input logic [31:0] col, input logic [7:0] bg,
                            input logic [10:0] oh, input logic [10:0] ov,
                            input logic ohs, input logic ovs, input logic ode, input logic oft,
                            input logic [7:0] opix);
    int ht, vt, h, v, m, hm, vm;
    logic ehs, evs, ede;
    logic [7:0] epix;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    h  = n % ht;
    v  = (n / ht) % vt;
    check_eq({p, "_hcnt"}, 32'(oh), 32'(h));
    check_eq({p, "_vcnt"}, 32'(ov), 32'(v));
    check_eq({p, "_frame_tick"}, 32'(oft), 32'((h == 0 && v == vv) ? 1 : 0));
    if (n < 2) begin
      ehs = 1'b1; evs = 1'b1; ede = 1'b0; epix = 8'h00;
    end else begin
      m    = n - 2;
      hm   = m % ht;
      vm   = (m / ht) % vt;
      ehs  = !(hm >= hv + hf && hm < hv + hf + hs);
      evs  = !(vm >= vv + vf && vm < vv + vf + vs);
      ede  = (hm < hv && vm < vv);
      epix = model_pix(hm, vm, hv, vv, en, col, bg);
    end
    check_eq({p, "_hsync"}, 32'(ohs), 32'(ehs));
    check_eq({p, "_vsync"}, 32'(ovs), 32'(evs));
    check_eq({p, "_de"},    32'(ode), 32'(ede));
    check_eq({p, "_rgb"},   32'(opix), 32'(epix));
  endtask

  // Every output of both instances at its reset value
  task automatic check_reset_values(input string p);
    check_eq({p, "_s_cnt"}, {10'h0, s_h, s_v}, 32'h0);
    check_eq({p, "_s_out"}, 32'({s_hs, s_vs, s_de, s_ft, s_r, s_g, s_b}), 32'h0C00);
    check_eq({p, "_b_cnt"}, {10'h0, b_h, b_v}, 32'h0);
    check_eq({p, "_b_out"}, 32'({b_hs, b_vs, b_de, b_ft, b_r, b_g, b_b}), 32'h0C00);
  endtask

  // Run cycles after a reset release at a falling edge; big instance checked
  // only for its first few lines
  task automatic run(input int cycles, input int big_cycles);
    logic [3:0]  en_m;
    logic [31:0] col_m;
    for (int n = 0; n < cycles; n++) begin
      if (n > 0) @(negedge clk);
      #1;
      en_m  = (n >= 2) ? en_hist[(n - 2) % 4] : 4'h0;
      col_m = (n >= 1) ? col_hist[(n - 1) % 4] : 32'h0;
      check_inst("small", n, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB,
                 en_m, col_m, SBG, s_h, s_v, s_hs, s_vs, s_de, s_ft, {s_r, s_g, s_b});
      if (n < big_cycles)
        check_inst("big", n, BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB,
                   4'hF, 32'hFFFF_FFFF, 8'h00, b_h, b_v, b_hs, b_vs, b_de, b_ft, {b_r, b_g, b_b});
      // Flags for this cycle; colour is the layer's registered output for
      // the flags it saw one cycle earlier
      s_en  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      s_col = $urandom;
      en_hist[n % 4]  = s_en;
      col_hist[n % 4] = s_col;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_values("rst_hold");
    rst = 1'b0;
    run(1800, 1800);

    // Mid-frame asynchronous reset, away from any clock edge
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("rst_mid");
    repeat (2) @(negedge clk);
    check_reset_values("rst_mid_hold");
    s_en = 4'h0;
    rst  = 1'b0;
    run(1200, 900);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/t03_vga_output_stage.md
# t03_vga_output_stage

Raster timing generator and final pixel compositor for the team 03 video path. Generates `Hcnt`/`Vcnt` for the sprite and text display blocks, collects their registered 8-bit colours and `is_N_displayed` flags, and resolves them by fixed priority into one pixel. Drives the RRRGGGBB VGA pins with sync and data-enable delayed to match.

## Interface
- `H_VISIBLE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync pulse width
- `H_BP`, 48, horizontal back porch
- `V_VISIBLE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width
- `V_BP`, 33, vertical back porch
- `BG_COLOR`, 8'h00, colour when no layer claims the pixel
- `clk`  in  1  pixel clock (25 MHz), all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `layer_en`  in  4  per-layer "pixel owned" flags (combinational from `Hcnt`/`Vcnt`, same cycle); bit 0 highest priority
- `layer_color`  in  32  per-layer colours, [8i+7:8i] = layer i, registered by the layer (one clk after its flag)
- `Hcnt`  out  11  current horizontal count, registered
- `Vcnt`  out  11  current vertical count, registered
- `hsync`  out  1  horizontal sync, active-low
- `vsync`  out  1  vertical sync, active-low
- `de`  out  1  data enable, high for visible pixels
- `red`  out  3  colour [7:5]
- `green`  out  3  colour [4:2]
- `blue`  out  2  colour [1:0]
- `frame_tick`  out  1  one-clk pulse at the start of vertical blanking

## Operation
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
- `Hcnt` increments every clk. At H_TOTAL-1 it wraps to 0 and `Vcnt` increments. `Vcnt` wraps from V_TOTAL-1 to 0 on the same edge that `Hcnt` wraps.
- Visible when `Hcnt` < H_VISIBLE and `Vcnt` < V_VISIBLE.
- hsync low when H_VISIBLE+H_FP ≤ `Hcnt` < H_VISIBLE+H_FP+H_SYNC (656..751).
- vsync low when V_VISIBLE+V_FP ≤ `Vcnt` < V_VISIBLE+V_FP+V_SYNC (490..491), over whole lines.
- Pipeline stage 1: register `layer_en`, visible, hsync_raw and vsync_raw. This aligns the flags with the registered `layer_color`.
- Compositor: select the lowest index i with `layer_en_d[i]`=1 and take `layer_color[8i+7:8i]`. If no bit is set, take BG_COLOR. If visible_d=0, force 8'h00 regardless of flags.
- Pipeline stage 2: register the compositor result into `{red,green,blue}`, and register visible_d, hsync_d and vsync_d into `de`, `hsync` and `vsync`.
- `frame_tick` = (`Hcnt`==0 && `Vcnt`==V_VISIBLE), decoded from the registered counters. Game logic uses it to update board state during blanking.
- No counter saturation. All compares are 11-bit unsigned.

## Timing
- Reset values:
  - `Hcnt`=0, `Vcnt`=0
  - all pipeline registers cleared
  - `red`/`green`/`blue`=0, `de`=0
  - `hsync`=1, `vsync`=1 (inactive)
  - `frame_tick`=0
- Counters start advancing on the first rising edge after `rst` falls.
- Latency: the pixel addressed by `Hcnt`=h in cycle t appears on `red`/`green`/`blue`/`de`/`hsync`/`vsync` in cycle t+2. Sync and colour are always mutually aligned.
- A layer's flag is sampled in cycle t and its colour is consumed in cycle t+1. A layer whose colour lags its flag by anything other than 1 clk is out of contract.
- Simultaneous flags: priority only; lower-priority colours are ignored.
- A flag asserted during blanking is ignored (output 0). This covers sprites straddling x = H_VISIBLE.
- `rst` mid-frame: all outputs return to reset values asynchronously. After release the raster restarts at (0,0), so the first frame after reset is full-length.
- `frame_tick` fires exactly once per frame (every 420000 clks).

## Test plan
- Reset then free-run: `Hcnt` wraps 799→0 and `Vcnt` increments 0→1 on the same edge. `Vcnt` wraps 524→0. Period between `frame_tick` pulses is 420000 clks.
- Sync windows: `hsync` is low for exactly 96 clks, starting 2 clks after `Hcnt`=656. `vsync` is low for exactly 1600 clks, on lines 490–491 delayed by 2 clks. `de` is high for 640 clks per line and for 480 lines only.
- Priority: drive `layer_en`=4'b0110 with colours L1=8'hE0 and L2=8'h1C at `Hcnt`=100, `Vcnt`=50 → 2 clks later `red`=3'b111, `green`=0, `blue`=0. Drive `layer_en`=4'b0000 → output BG_COLOR.
- Alignment: a layer model registering its colour one clk after its flag, showing 8'h03 only at `Hcnt`=10 → `blue`=2'b11 for exactly one clk, 2 clks after `Hcnt`=10, and 0 on both neighbours.
- Blanking: `layer_en`=4'b1111 with all colours 8'hFF held high constantly → `red`/`green`/`blue`=0 whenever `de`=0, including at `Hcnt`=640–799 and lines 480–524.
- Mid-frame reset: assert `rst` at `Hcnt`=300, `Vcnt`=200 → all outputs immediately go to reset values (`hsync`=`vsync`=1). After release, `Hcnt` counts 0,1,2… and `frame_tick` first fires at `Vcnt`=480, `Hcnt`=0.
